instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the down-sampling processor. It holds the program counter, reads 10-bit instructions from the synchronous instruction ROM on request from the control unit, and delivers each word to the instruction register, which captures it on the falling clock edge while `ir_en` is high. It supports absolute jumps and stops permanently on a HALT opcode until reset.

## Interface
- `IW`, 10: instruction width; matches the instruction register.
- `AW`, 8: instruction ROM address width.
- `HALT_CODE`, 10'h3FF: opcode that halts fetching.

- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `fetch_req` input 1: control unit requests the next instruction; sampled only in IDLE.
- `jump` input 1: load the PC with `jump_addr`; sampled only in IDLE.
- `jump_addr` input AW: jump target.
- `imem_en` output 1: ROM read enable.
- `imem_addr` output AW: ROM address, always equal to `pc`.
- `imem_rdata` input IW: ROM data, valid one cycle after an enabled address.
- `ir_wdata` output IW: instruction word to the instruction register (`Rin`).
- `ir_en` output 1: instruction register write enable (`EnWrite`); a one-cycle pulse.
- `fetch_done` output 1: one-cycle pulse, coincident with `ir_en`.
- `busy` output 1: high when the state is not IDLE.
- `halted` output 1: sticky flag, set after a HALT instruction is delivered.
- `pc` output AW: current program counter.

## Operation
- States: IDLE, READ, LATCH, WRITE. Encoding is free.
- **IDLE:**
  - `fetch_req=1` and `jump=1`: `pc <= jump_addr`, go to READ. The fetch uses the jump target.
  - `fetch_req=1` only: go to READ.
  - `jump=1` only: `pc <= jump_addr`, stay in IDLE.
  - If `halted=1`, both `fetch_req` and `jump` are ignored.
- **READ:**
  - `imem_en=1` and `imem_addr=pc`.
  - Go to LATCH.
- **LATCH:**
  - `ir_wdata <= imem_rdata` at the end of the cycle.
  - Go to WRITE.
- **WRITE:**
  - `ir_en=1` and `fetch_done=1` for exactly this cycle.
  - `pc <= pc+1` at the end of the cycle, modulo 2^AW (2^AW−1 wraps to 0).
  - If `ir_wdata==HALT_CODE`: `halted <= 1`, and the PC is not incremented.
  - Go to IDLE.
- `fetch_req` and `jump` asserted in READ, LATCH or WRITE are ignored and not queued. The control unit re-requests after `fetch_done`.
- `ir_wdata` holds its value between fetches.
- A HALT word is still delivered to the instruction register so the control unit can see it.
- **Reset values** (reset takes priority over all other inputs):
  - state = IDLE
  - `pc`, `imem_addr` = 0
  - `ir_wdata` = 0
  - `imem_en`, `ir_en`, `fetch_done`, `busy`, `halted` = 0
- **Reset mid-fetch:** aborts the fetch. No `ir_en` pulse follows, and the PC returns to 0.

## Timing
- `fetch_req` sampled in IDLE at cycle n gives:
  - READ at n+1, with `imem_en` high.
  - LATCH at n+2, with ROM data valid.
  - WRITE at n+3, with `ir_en` and `fetch_done` high.
  - IDLE at n+4.
- Fetch latency is 3 cycles. The maximum rate is one instruction per 4 cycles.
- `ir_wdata` is stable for the whole WRITE cycle. The instruction register samples it on the falling edge inside WRITE, so setup and hold are half a cycle each.
- `ir_en`, `fetch_done`, `imem_en` and `busy` are decoded from the registered state only. None of them has a combinational path from `fetch_req` or `jump`.
- `pc` changes at the end of WRITE. It shows the next address from the first IDLE cycle onward.
- A jump in IDLE takes effect on `pc` and `imem_addr` in the following cycle.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` for 2 cycles with `fetch_req=1`.
  - Response: all outputs 0, state IDLE, no `imem_en`.
- **Sequential fetch:**
  - Stimulus: ROM[0..2] = 10'h011, 10'h022, 10'h033; three requests, each issued in the cycle after the previous `fetch_done`.
  - Response: `ir_en` pulses at cycles 3, 7, 11 relative to the first request, carrying 011, 022, 033. `pc` ends at 3.
- **Jump:**
  - Stimulus (a): `jump=1`, `jump_addr=8'h40` with `fetch_req=1`. Response: ROM[0x40] is delivered and `pc` ends at 0x41.
  - Stimulus (b): jump alone. Response: `pc=0x40` and no fetch.
- **Wrap and busy:**
  - Stimulus: jump to 0xFF, fetch, and pulse `fetch_req` during LATCH.
  - Response: ROM[0xFF] is delivered, `pc` wraps to 0x00, and exactly one `ir_en` pulse occurs.
- **Halt:**
  - Stimulus: ROM[5]=10'h3FF; fetch from 5, then request again.
  - Response: 3FF is delivered, `halted=1`, `pc` stays 5, and later requests and jumps give no `imem_en`.
- **Reset mid-fetch:**
  - Stimulus: assert `rst` in LATCH.
  - Response: no `ir_en` pulse, `pc=0`, `halted=0`, and a new request fetches ROM[0].

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit, the control unit, the instruction ROM
// and the instruction register.
interface instr_fetch_unit_if #(
  parameter int IW = 10,
  parameter int AW = 8
) ();
  logic          fetch_req;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] ir_wdata;
  logic          ir_en;
  logic          fetch_done;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;

  // Control unit / ROM / instruction register side
  modport master (
    output fetch_req, jump, jump_addr, imem_rdata,
    input  imem_en, imem_addr, ir_wdata, ir_en, fetch_done, busy, halted, pc
  );

  // Fetch unit side
  modport slave (
    input  fetch_req, jump, jump_addr, imem_rdata,
    output imem_en, imem_addr, ir_wdata, ir_en, fetch_done, busy, halted, pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads the synchronous
// instruction ROM and hands each word to the instruction register. A HALT
// word stops all further fetches and jumps until reset.
module instr_fetch_unit #(
  parameter int          IW        = 10,
  parameter int          AW        = 8,
  parameter logic [IW-1:0] HALT_CODE = 10'h3FF
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] irData_q, irData_d;
  logic          halted_q, halted_d;

  // State, PC, fetched word and halt flag; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      irData_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      irData_q <= irData_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic; requests outside IDLE are dropped, not queued, and a
  // jump combined with a request makes the fetch use the jump target.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    irData_d = irData_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        if (!halted_q) begin
          if (bus.jump) begin
            pc_d = bus.jump_addr;
          end
          if (bus.fetch_req) begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        irData_d = bus.imem_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        if (irData_q == HALT_CODE) begin
          halted_d = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode only the registered state, so no request/jump input
  // reaches an output combinationally.
  assign bus.imem_en    = (state_q == READ);
  assign bus.ir_en      = (state_q == WRITE);
  assign bus.fetch_done = (state_q == WRITE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.ir_wdata   = irData_q;
  assign bus.halted     = halted_q;

endmodule
